// File: rtl/mul_div_result_collector_if.sv
// Handshake bundle between the issue side, the mul_div result bus and the
// result consumer of mul_div_result_collector.
interface mul_div_result_collector_if #(
    parameter int N = 10
);
    logic           issue;
    logic           issue_sel;
    logic           issue_ready;
    logic [2*N-1:0] R;
    logic [4:0]     flags;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_R;
    logic [4:0]     out_flags;
    logic           out_sel;
    logic           ovf_err;
    logic [15:0]    res_cnt;

    modport slave (
        input  issue, issue_sel, R, flags, out_ready,
        output issue_ready, out_valid, out_R, out_flags, out_sel, ovf_err, res_cnt
    );

    modport master (
        output issue, issue_sel, R, flags, out_ready,
        input  issue_ready, out_valid, out_R, out_flags, out_sel, ovf_err, res_cnt
    );
endinterface

// File: rtl/mul_div_result_collector.sv
// Tracks operations issued to a fixed-latency mul_div and captures each result,
// its flags and its operation type into a first-word-fall-through FIFO.
module mul_div_result_collector #(
    parameter int N     = 10,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input logic                    clk,
    input logic                    arst,
    mul_div_result_collector_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [2*N-1:0] r;
        logic [4:0]     f;
        logic           s;
    } entry_t;

    logic [LAT-1:0] valid_q, valid_d;
    logic [LAT-1:0] sel_q, sel_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [15:0]    res_cnt_q, res_cnt_d;
    entry_t         mem_q [DEPTH];
    entry_t         head;
    entry_t         wr_entry;

    logic [4:0]     inflight;
    logic [5:0]     occupancy;
    logic           issue_ready;
    logic           empty, full, arrive, push, pop;

    always_comb begin
        valid_d    = '0;
        sel_d      = '0;
        valid_d[0] = bus.issue;
        sel_d[0]   = bus.issue_sel;
        for (int i = 1; i < LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            sel_d[i]   = sel_q[i-1];
        end
    end

    // Credit check: a slot is reserved for every tag still travelling down the pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + 5'(valid_q[i]);
        end
        occupancy   = 6'(count_q) + 6'(inflight);
        issue_ready = occupancy < 6'(DEPTH);
    end

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == CW'(DEPTH));
        arrive     = valid_q[LAT-1];
        pop        = !empty && bus.out_ready;
        push       = arrive && (!full || pop);
        wr_entry.r = bus.R;
        wr_entry.f = bus.flags;
        wr_entry.s = sel_q[LAT-1];
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        ovf_d      = ovf_q | (bus.issue & ~issue_ready);
        res_cnt_d  = res_cnt_q + 16'(pop);
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            valid_q   <= '0;
            sel_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            res_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            sel_q     <= sel_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            res_cnt_q <= res_cnt_d;
        end
    end

    // Storage needs no reset: nothing is visible unless the count says it is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head            = mem_q[rd_ptr_q];
    assign bus.issue_ready = issue_ready;
    assign bus.out_valid   = !empty;
    assign bus.out_R       = empty ? '0 : head.r;
    assign bus.out_flags   = empty ? '0 : head.f;
    assign bus.out_sel     = empty ? 1'b0 : head.s;
    assign bus.ovf_err     = ovf_q;
    assign bus.res_cnt     = res_cnt_q;
endmodule

// File: doc/mul_div_result_collector.md
MUL_DIV_RESULT_COLLECTOR -- requirements
Module: mul_div_result_collector

Interface
REQ-001 Parameter N, default 10: operand width of the upstream mul_div; result width is 2N.
REQ-002 Parameter LAT, default 2: clock cycles from an issue edge to the valid R and flags at the mul_div outputs; legal range 1..8.
REQ-003 Parameter DEPTH, default 4: result FIFO entries; a power of two, 2..16.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 arst  in  1  reset; asynchronous, active-low.
REQ-006 issue  in  1  pulse, high for one cycle per operation presented to mul_div with en=1.
REQ-007 issue_sel  in  1  sel value of the issued operation: 0=mul, 1=div.
REQ-008 issue_ready  out  1  collector can accept an issue this cycle.
REQ-009 R  in  2N  mul_div result.
REQ-010 flags  in  5  {io_flag, dz_flag, of_flag, uf_flag, i_flag} from mul_div.
REQ-011 out_valid  out  1  FIFO head holds a result.
REQ-012 out_ready  in  1  consumer accepts the head.
REQ-013 out_R  out  2N  head result.
REQ-014 out_flags  out  5  head flags, same bit order as flags.
REQ-015 out_sel  out  1  head operation type.
REQ-016 ovf_err  out  1  sticky; set when an issue is accepted while issue_ready=0.
REQ-017 res_cnt  out  16  count of results popped by the consumer.

Function
REQ-018 A LAT-stage shift register carries {valid, sel}; stage 0 loads {issue, issue_sel} each cycle.
REQ-019 When the last stage is valid, R, flags and the carried sel are pushed into the FIFO in that cycle; R and flags are sampled exactly LAT cycles after issue.
REQ-020 inflight = number of valid stages; issue_ready = (fifo_count + inflight) < DEPTH, purely combinational from registered state.
REQ-021 Issue while issue_ready=0: the tag still enters the pipeline; ovf_err sets; a push into a full FIFO is dropped and the FIFO contents stay unchanged.
REQ-022 Pop occurs when out_valid and out_ready are both high; out_R, out_flags and out_sel are driven from the head entry, first-word-fall-through.
REQ-023 Push and pop in the same cycle with FIFO non-empty: both take effect and fifo_count is unchanged.
REQ-024 Push and pop in the same cycle with FIFO full: pop first, then push; no drop, no ovf_err.
REQ-025 Push with FIFO empty: out_valid rises the next cycle; there is no same-cycle bypass.
REQ-026 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH; fifo_count is log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-027 res_cnt increments by 1 per pop and wraps from 0xFFFF to 0.
REQ-028 out_valid and issue_ready hold steady while out_ready is low; head data holds stable until popped.

Reset
REQ-029 arst low: asynchronously clear the shift register, the pointers, fifo_count, ovf_err and res_cnt.
REQ-030 While arst is low: out_valid=0, issue_ready=1, out_R=0, out_flags=0, out_sel=0, ovf_err=0, res_cnt=0.
REQ-031 Reset mid-operation: in-flight tags and buffered results are discarded; none appear after release.
REQ-032 Release is synchronous to clk; the first issue is accepted on the first rising edge after arst goes high.

Verification
REQ-033 LAT=2, issue with sel=0 at cycle 0, R=0x00C8 and flags=0 at cycle 2, out_ready=1 -> out_valid at cycle 3 with out_R=0x00C8 and out_sel=0; res_cnt=1 at cycle 4.
REQ-034 out_ready=0, issue every cycle -> issue_ready drops after 4 issues (DEPTH=4); all 4 results pop in order once out_ready=1; ovf_err=0.
REQ-035 Forced 5th issue while issue_ready=0 -> ovf_err=1 and stays 1; FIFO holds the first 4 results unchanged.
REQ-036 FIFO full with out_ready=1 and a simultaneous push -> count stays 4, no drop, order preserved.
REQ-037 dz_flag=1 on a div result -> out_flags=5'b01000 and out_sel=1.
REQ-038 arst pulsed low with 2 in flight and 3 buffered -> out_valid=0 and res_cnt=0 immediately; no results after release.
